// File: rtl/change_dispenser.sv
// Change payout controller: greedy, stock-aware split of an amount into 10/5/1 yuan
// units, each paid through one 4-phase req/ack transaction with the hopper.
module change_dispenser #(
    parameter int AMT_W   = 5,
    parameter int STOCK_W = 8,
    parameter int INIT_10 = 8,
    parameter int INIT_5  = 20,
    parameter int INIT_1  = 50,
    parameter int ACK_TMO = 1000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [AMT_W-1:0]   change_amt,
    input  logic               refill,
    input  logic               hop_ack,
    output logic               req_10,
    output logic               req_5,
    output logic               req_1,
    output logic               busy,
    output logic               done,
    output logic               error,
    output logic [AMT_W-1:0]   remaining,
    output logic [STOCK_W-1:0] stock_10,
    output logic [STOCK_W-1:0] stock_5,
    output logic [STOCK_W-1:0] stock_1
);

    localparam int TMO_W = $clog2(ACK_TMO + 1);
    localparam logic [TMO_W-1:0]   TMO_LAST = TMO_W'(ACK_TMO - 1);
    localparam logic [AMT_W-1:0]   AMT_10   = AMT_W'(10);
    localparam logic [AMT_W-1:0]   AMT_5    = AMT_W'(5);
    localparam logic [AMT_W-1:0]   AMT_1    = AMT_W'(1);
    localparam logic [STOCK_W-1:0] ONE_UNIT = STOCK_W'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SEL,
        S_REQ,
        S_WAITREL,
        S_DONE,
        S_ERR
    } state_t;

    typedef enum logic [1:0] {
        D_NONE,
        D_10,
        D_5,
        D_1
    } den_t;

    state_t             state_q, state_d;
    den_t               den_q, den_d;
    logic [AMT_W-1:0]   rem_q, rem_d;
    logic [STOCK_W-1:0] s10_q, s10_d;
    logic [STOCK_W-1:0] s5_q, s5_d;
    logic [STOCK_W-1:0] s1_q, s1_d;
    logic [TMO_W-1:0]   tmo_q, tmo_d;
    logic [AMT_W-1:0]   den_amt;

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            state_q <= S_IDLE;
            den_q   <= D_NONE;
            rem_q   <= '0;
            s10_q   <= STOCK_W'(INIT_10);
            s5_q    <= STOCK_W'(INIT_5);
            s1_q    <= STOCK_W'(INIT_1);
            tmo_q   <= '0;
        end else begin
            state_q <= state_d;
            den_q   <= den_d;
            rem_q   <= rem_d;
            s10_q   <= s10_d;
            s5_q    <= s5_d;
            s1_q    <= s1_d;
            tmo_q   <= tmo_d;
        end
    end

    always_comb begin
        den_amt = '0;
        unique case (den_q)
            D_10:    den_amt = AMT_10;
            D_5:     den_amt = AMT_5;
            D_1:     den_amt = AMT_1;
            default: den_amt = '0;
        endcase
    end

    always_comb begin
        // NOTE: every next-state value gets a default first so no path leaves a latch behind.
        state_d = state_q;
        den_d   = den_q;
        rem_d   = rem_q;
        s10_d   = s10_q;
        s5_d    = s5_q;
        s1_d    = s1_q;
        tmo_d   = tmo_q;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    rem_d   = change_amt;
                    state_d = S_SEL;
                end else if (refill) begin
                    s10_d = STOCK_W'(INIT_10);
                    s5_d  = STOCK_W'(INIT_5);
                    s1_d  = STOCK_W'(INIT_1);
                end
            end
            S_SEL: begin
                den_d = D_NONE;
                tmo_d = '0;
                if (rem_q == '0) begin
                    state_d = S_DONE;
                end else if (rem_q >= AMT_10 && s10_q != '0) begin
                    den_d   = D_10;
                    state_d = S_REQ;
                end else if (rem_q >= AMT_5 && s5_q != '0) begin
                    den_d   = D_5;
                    state_d = S_REQ;
                end else if (s1_q != '0) begin
                    den_d   = D_1;
                    state_d = S_REQ;
                end else begin
                    state_d = S_ERR;
                end
            end
            S_REQ: begin
                tmo_d = tmo_q + TMO_W'(1);
                // An acknowledge on the final allowed cycle still completes the unit.
                if (hop_ack) begin
                    rem_d   = rem_q - den_amt;
                    state_d = S_WAITREL;
                    unique case (den_q)
                        D_10:    s10_d = s10_q - ONE_UNIT;
                        D_5:     s5_d  = s5_q - ONE_UNIT;
                        D_1:     s1_d  = s1_q - ONE_UNIT;
                        default: ;
                    endcase
                end else if (tmo_q == TMO_LAST) begin
                    state_d = S_ERR;
                end
            end
            S_WAITREL: begin
                tmo_d = tmo_q + TMO_W'(1);
                if (!hop_ack) begin
                    state_d = S_SEL;
                end else if (tmo_q == TMO_LAST) begin
                    state_d = S_ERR;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            S_ERR: begin
                if (start) begin
                    rem_d   = change_amt;
                    state_d = S_SEL;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign req_10    = (state_q == S_REQ) && (den_q == D_10);
    assign req_5     = (state_q == S_REQ) && (den_q == D_5);
    assign req_1     = (state_q == S_REQ) && (den_q == D_1);
    assign busy      = (state_q == S_SEL) || (state_q == S_REQ) || (state_q == S_WAITREL);
    assign done      = (state_q == S_DONE);
    // ERR is only left by a new start, so the flag is sticky through the state itself.
    assign error     = (state_q == S_ERR);
    assign remaining = rem_q;
    assign stock_10  = s10_q;
    assign stock_5   = s5_q;
    assign stock_1   = s1_q;

endmodule

// File: tb/tb_change_dispenser.sv
// Directed bench for change_dispenser: hopper responder plus per-scenario tasks
// with hand-computed expectations.
module tb_change_dispenser;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [4:0] change_amt;
    logic       refill;
    logic       hop_ack;
    logic       req_10, req_5, req_1;
    logic       busy, done, error;
    logic [4:0] remaining;
    logic [7:0] stock_10, stock_5, stock_1;

    int pass_cnt  = 0;
    int total_cnt = 0;

    int seq [0:31];
    int seq_n;
    bit done_seen;
    bit req_seen;

    change_dispenser dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .change_amt (change_amt),
        .refill     (refill),
        .hop_ack    (hop_ack),
        .req_10     (req_10),
        .req_5      (req_5),
        .req_1      (req_1),
        .busy       (busy),
        .done       (done),
        .error      (error),
        .remaining  (remaining),
        .stock_10   (stock_10),
        .stock_5    (stock_5),
        .stock_1    (stock_1)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Starts a payout and acts as the hopper until done or error appears.
    task automatic pay(input logic [4:0] amt, input logic with_refill);
        seq_n     = 0;
        done_seen = 1'b0;
        change_amt = amt;
        refill     = with_refill;
        start      = 1'b1;
        tick();
        start  = 1'b0;
        refill = 1'b0;
        for (int i = 0; i < 600; i++) begin
            if (done) begin
                done_seen = 1'b1;
                break;
            end
            if (error) break;
            if (req_10 || req_5 || req_1) begin
                seq[seq_n] = req_10 ? 10 : (req_5 ? 5 : 1);
                seq_n++;
                hop_ack = 1'b1;
                tick();
                hop_ack = 1'b0;
                tick();
            end else begin
                tick();
            end
        end
        if (done_seen) tick();
    endtask

    task automatic test_reset();
        do_reset();
        total_cnt++;
        if ({req_10, req_5, req_1, busy, done, error} !== 6'b0) begin
            $display("FAIL reset_flags: got %b want 000000", {req_10, req_5, req_1, busy, done, error});
        end else pass_cnt++;
        total_cnt++;
        if (remaining !== 5'd0) $display("FAIL reset_remaining: got %0d want 0", remaining);
        else pass_cnt++;
        total_cnt++;
        if ({stock_10, stock_5, stock_1} !== {8'd8, 8'd20, 8'd50}) begin
            $display("FAIL reset_stocks: got %0d/%0d/%0d want 8/20/50", stock_10, stock_5, stock_1);
        end else pass_cnt++;
    endtask

    task automatic test_pay17();
        do_reset();
        pay(5'd17, 1'b0);
        total_cnt++;
        if (seq_n !== 4 || seq[0] !== 10 || seq[1] !== 5 || seq[2] !== 1 || seq[3] !== 1) begin
            $display("FAIL pay17_sequence: got n=%0d %0d,%0d,%0d,%0d want n=4 10,5,1,1",
                     seq_n, seq[0], seq[1], seq[2], seq[3]);
        end else pass_cnt++;
        total_cnt++;
        if (!done_seen || remaining !== 5'd0) begin
            $display("FAIL pay17_done: got done=%0b rem=%0d want done=1 rem=0", done_seen, remaining);
        end else pass_cnt++;
        total_cnt++;
        if ({stock_10, stock_5, stock_1} !== {8'd7, 8'd19, 8'd48}) begin
            $display("FAIL pay17_stocks: got %0d/%0d/%0d want 7/19/48", stock_10, stock_5, stock_1);
        end else pass_cnt++;
    endtask

    task automatic test_zero();
        do_reset();
        req_seen   = 1'b0;
        change_amt = 5'd0;
        start      = 1'b1;
        tick();
        start = 1'b0;
        req_seen |= req_10 | req_5 | req_1;
        total_cnt++;
        if ({busy, done} !== 2'b10) $display("FAIL zero_sel: got busy,done=%b want 10", {busy, done});
        else pass_cnt++;
        tick();
        req_seen |= req_10 | req_5 | req_1;
        total_cnt++;
        if ({busy, done} !== 2'b01) $display("FAIL zero_done: got busy,done=%b want 01", {busy, done});
        else pass_cnt++;
        tick();
        req_seen |= req_10 | req_5 | req_1;
        total_cnt++;
        if ({busy, done, req_seen} !== 3'b000) begin
            $display("FAIL zero_after: got busy,done,req_seen=%b want 000", {busy, done, req_seen});
        end else pass_cnt++;
    endtask

    task automatic test_no5();
        int bad;
        do_reset();
        for (int k = 0; k < 20; k++) pay(5'd5, 1'b0);
        total_cnt++;
        if (stock_5 !== 8'd0) $display("FAIL no5_drain: got stock_5=%0d want 0", stock_5);
        else pass_cnt++;
        pay(5'd7, 1'b0);
        bad = 0;
        for (int k = 0; k < seq_n; k++) if (seq[k] != 1) bad++;
        total_cnt++;
        if (seq_n !== 7 || bad !== 0 || !done_seen) begin
            $display("FAIL no5_ones: got n=%0d non1=%0d done=%0b want n=7 non1=0 done=1", seq_n, bad, done_seen);
        end else pass_cnt++;
        total_cnt++;
        if (stock_1 !== 8'd43) $display("FAIL no5_stock1: got %0d want 43", stock_1);
        else pass_cnt++;
    endtask

    task automatic test_no1();
        do_reset();
        for (int k = 0; k < 12; k++) pay(5'd4, 1'b0);
        pay(5'd2, 1'b0);
        total_cnt++;
        if (stock_1 !== 8'd0) $display("FAIL no1_drain: got stock_1=%0d want 0", stock_1);
        else pass_cnt++;
        pay(5'd3, 1'b0);
        total_cnt++;
        if ({error, busy} !== 2'b10 || seq_n !== 0 || remaining !== 5'd3) begin
            $display("FAIL no1_err: got err,busy=%b n=%0d rem=%0d want 10 n=0 rem=3",
                     {error, busy}, seq_n, remaining);
        end else pass_cnt++;
        refill = 1'b1;
        tick();
        refill = 1'b0;
        total_cnt++;
        if (stock_1 !== 8'd0 || error !== 1'b1) begin
            $display("FAIL no1_refill_in_err: got stock_1=%0d err=%0b want 0 1", stock_1, error);
        end else pass_cnt++;
        pay(5'd0, 1'b0);
        refill = 1'b1;
        tick();
        refill = 1'b0;
        total_cnt++;
        if (stock_1 !== 8'd50 || error !== 1'b0 || !done_seen) begin
            $display("FAIL no1_recover: got stock_1=%0d err=%0b done=%0b want 50 0 1", stock_1, error, done_seen);
        end else pass_cnt++;
    endtask

    task automatic test_timeout();
        int cnt;
        do_reset();
        change_amt = 5'd10;
        start      = 1'b1;
        tick();
        start = 1'b0;
        tick();
        cnt = 0;
        while (req_10 && cnt < 1100) begin
            cnt++;
            tick();
        end
        total_cnt++;
        if (cnt !== 1000) $display("FAIL tmo_cycles: got req_10 held %0d want 1000", cnt);
        else pass_cnt++;
        total_cnt++;
        if ({error, req_10, busy} !== 3'b100 || remaining !== 5'd10 || stock_10 !== 8'd8) begin
            $display("FAIL tmo_err: got err,req,busy=%b rem=%0d s10=%0d want 100 rem=10 s10=8",
                     {error, req_10, busy}, remaining, stock_10);
        end else pass_cnt++;
        change_amt = 5'd0;
        start      = 1'b1;
        tick();
        start = 1'b0;
        total_cnt++;
        if ({error, busy} !== 2'b01) $display("FAIL tmo_restart: got err,busy=%b want 01", {error, busy});
        else pass_cnt++;
        tick();
        tick();
    endtask

    task automatic test_rst_midhandshake();
        do_reset();
        change_amt = 5'd17;
        start      = 1'b1;
        tick();
        start = 1'b0;
        tick();
        total_cnt++;
        if (req_10 !== 1'b1) $display("FAIL latency_req10: got req_10=%0b at start+2 want 1", req_10);
        else pass_cnt++;
        hop_ack = 1'b1;
        tick();
        rst = 1'b1;
        tick();
        rst     = 1'b0;
        hop_ack = 1'b0;
        total_cnt++;
        if ({req_10, req_5, req_1, busy, done, error} !== 6'b0 || remaining !== 5'd0 ||
            {stock_10, stock_5, stock_1} !== {8'd8, 8'd20, 8'd50}) begin
            $display("FAIL rst_mid: got flags=%b rem=%0d stocks=%0d/%0d/%0d want 000000 0 8/20/50",
                     {req_10, req_5, req_1, busy, done, error}, remaining, stock_10, stock_5, stock_1);
        end else pass_cnt++;
        pay(5'd10, 1'b0);
        pay(5'd10, 1'b1);
        total_cnt++;
        if (stock_10 !== 8'd6 || !done_seen) begin
            $display("FAIL start_beats_refill: got stock_10=%0d done=%0b want 6 1", stock_10, done_seen);
        end else pass_cnt++;
        refill = 1'b1;
        tick();
        refill = 1'b0;
        total_cnt++;
        if (stock_10 !== 8'd8) $display("FAIL refill_idle: got stock_10=%0d want 8", stock_10);
        else pass_cnt++;
    endtask

    initial begin
        rst        = 1'b1;
        start      = 1'b0;
        change_amt = 5'd0;
        refill     = 1'b0;
        hop_ack    = 1'b0;
        test_reset();
        test_pay17();
        test_zero();
        test_no5();
        test_no1();
        test_timeout();
        test_rst_midhandshake();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
